// File: rtl/conv_weight_loader.sv
// conv_weight_loader: streams KERNEL_SIZE*KERNEL_SIZE signed weights from a valid/ready source onto the PE weight-write bus
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start             begin a load (only honoured in IDLE)
//   i_abort             cancel an in-progress load (only effective in LOAD)
//   s_valid/s_ready/s_w weight beat handshake and data
//   o_w_en/o_addr/o_w   registered PE write strobe, address and data
//   o_busy              high while loading
//   o_done              one-cycle pulse once the last weight is written
//   o_checksum          running signed sum of accepted weights (only with WLOAD_CHECKSUM_EN)
//
// Optional feature macro: WLOAD_CHECKSUM_EN
module conv_weight_loader #(
    parameter int KERNEL_SIZE = 5,
    parameter int WEIGHT_BW   = 8,
    parameter int ADDR_BW     = 5,
    parameter int BASE_ADDR   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        s_valid,
    input  logic signed [WEIGHT_BW-1:0] s_w,
    output logic                        s_ready,
    output logic                        o_w_en,
    output logic        [ADDR_BW-1:0]   o_addr,
    output logic signed [WEIGHT_BW-1:0] o_w,
    output logic                        o_busy,
    output logic                        o_done
`ifdef WLOAD_CHECKSUM_EN
    ,
    output logic signed [WEIGHT_BW+ADDR_BW-1:0] o_checksum
`endif
);
    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          start_load;

    assign accept     = s_valid && s_ready;
    assign start_load = (state == IDLE) && i_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Abort takes priority over a same-cycle beat by withholding s_ready.
    always_comb begin
        next    = state;
        s_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state)
            IDLE: next = i_start ? LOAD : IDLE;
            LOAD: begin
                s_ready = !i_abort;
                o_busy  = 1'b1;
                next    = i_abort ? IDLE : (s_valid && cnt == LAST) ? DONE : LOAD;
            end
            DONE: begin
                o_done = 1'b1;
                next   = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            o_w_en <= 1'b0;
            o_addr <= '0;
            o_w    <= '0;
        end else begin
            o_w_en <= accept;
            if (start_load) cnt <= '0;
            else if (accept) cnt <= cnt + 1'b1;
            if (accept) begin
                o_addr <= ADDR_BW'(BASE_ADDR) + ADDR_BW'(cnt);
                o_w    <= s_w;
            end
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          o_checksum <= '0;
        else if (start_load) o_checksum <= '0;
        else if (accept)     o_checksum <= o_checksum + {{ADDR_BW{s_w[WEIGHT_BW-1]}}, s_w};
    end
`endif
endmodule

// File: tb/tb_conv_weight_loader.sv
// tb_conv_weight_loader: randomized self-checking bench for conv_weight_loader against a behavioural load model
module tb_conv_weight_loader;
    localparam int N0 = 25;
    localparam int B0 = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0, i_abort = 1'b0, s_valid = 1'b0;
    logic signed [7:0] s_w = '0;
    logic              s_ready, o_w_en, o_busy, o_done;
    logic        [4:0] o_addr;
    logic signed [7:0] o_w;
    logic              st1 = 1'b0, ab1 = 1'b0, v1 = 1'b0;
    logic signed [7:0] w1 = '0;
    logic              ready1, wen1, busy1, done1;
    logic        [4:0] addr1;
    logic signed [7:0] ow1;
`ifdef WLOAD_CHECKSUM_EN
    logic signed [12:0] o_checksum, cs1;
`endif

    always #5 clk = ~clk;

    conv_weight_loader dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .s_valid(s_valid), .s_w(s_w), .s_ready(s_ready), .o_w_en(o_w_en),
        .o_addr(o_addr), .o_w(o_w), .o_busy(o_busy), .o_done(o_done)
`ifdef WLOAD_CHECKSUM_EN
        , .o_checksum(o_checksum)
`endif
    );

    conv_weight_loader #(.KERNEL_SIZE(3), .BASE_ADDR(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .i_start(st1), .i_abort(ab1),
        .s_valid(v1), .s_w(w1), .s_ready(ready1), .o_w_en(wen1),
        .o_addr(addr1), .o_w(ow1), .o_busy(busy1), .o_done(done1)
`ifdef WLOAD_CHECKSUM_EN
        , .o_checksum(cs1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: whether a load is open, how many weights it has taken, their sum,
    // and the last write expected on the bus.
    bit                m_load, m_done;
    int                m_cnt, m_sum;
    bit                e_wen;
    logic        [4:0] e_addr;
    logic signed [7:0] e_w;

    int q_addr[$];
    int q_w[$];
    int n_done;

    task automatic model_reset();
        m_load = 0; m_done = 0; m_cnt = 0; m_sum = 0;
        e_wen = 0; e_addr = '0; e_w = '0;
    endtask

    task automatic clear_sb();
        q_addr.delete(); q_w.delete(); n_done = 0;
    endtask

    // Drive one cycle at the falling edge, predict, then check every output at the next falling edge.
    task automatic step(input bit st, input bit ab, input bit v, input logic signed [7:0] w);
        bit acc, dn;
        i_start = st; i_abort = ab; s_valid = v; s_w = w;
        #1;
        n_cmp++;
        if (s_ready !== (m_load && !ab)) begin
            n_err++; $display("FAIL s_ready got %b exp %b", s_ready, m_load && !ab);
        end
        acc = v && m_load && !ab;
        dn  = acc && (m_cnt == N0 - 1);
        e_wen = acc;
        if (acc) begin
            e_addr = 5'(B0 + m_cnt); e_w = w; m_sum += int'(w); m_cnt++;
        end
        if (!m_load && !m_done && st) begin
            m_load = 1; m_cnt = 0; m_sum = 0;
        end else if (m_load && (ab || dn)) m_load = 0;
        m_done = dn;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_w_en !== e_wen) begin n_err++; $display("FAIL o_w_en got %b exp %b", o_w_en, e_wen); end
        n_cmp++;
        if (o_addr !== e_addr) begin n_err++; $display("FAIL o_addr got %0d exp %0d", o_addr, e_addr); end
        n_cmp++;
        if (o_w !== e_w) begin n_err++; $display("FAIL o_w got %0d exp %0d", o_w, e_w); end
        n_cmp++;
        if (o_busy !== m_load) begin n_err++; $display("FAIL o_busy got %b exp %b", o_busy, m_load); end
        n_cmp++;
        if (o_done !== m_done) begin n_err++; $display("FAIL o_done got %b exp %b", o_done, m_done); end
`ifdef WLOAD_CHECKSUM_EN
        n_cmp++;
        if (o_checksum !== 13'(m_sum)) begin n_err++; $display("FAIL o_checksum got %0d exp %0d", o_checksum, m_sum); end
`endif
        if (o_w_en === 1'b1) begin q_addr.push_back(int'(o_addr)); q_w.push_back(int'(o_w)); end
        if (o_done === 1'b1) begin
            n_done++;
            n_cmp++;
            if (!(o_w_en === 1'b1 && o_addr === 5'(B0 + N0 - 1))) begin
                n_err++; $display("FAIL done_with_last en %b addr %0d exp 1 %0d", o_w_en, o_addr, B0 + N0 - 1);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({s_ready, o_w_en, o_addr, o_w, o_busy, o_done} !== '0) begin
            n_err++; $display("FAIL reset_outputs got %h exp 0", {s_ready, o_w_en, o_addr, o_w, o_busy, o_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_sb();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom));
        n_cmp++;
        if (q_addr.size() != 0) begin n_err++; $display("FAIL idle_writes got %0d exp 0", q_addr.size()); end
    endtask

    task automatic test_full_load();
        clear_sb();
        step(1, 0, 0, 0);
        for (int i = 1; i <= N0; i++) step(0, 0, 1, 8'(i));
        step(0, 0, 1, 8'd99);
        step(0, 0, 0, 0);
        n_cmp++;
        if (q_addr.size() != N0) begin n_err++; $display("FAIL full_count got %0d exp %0d", q_addr.size(), N0); end
        for (int i = 0; i < q_addr.size() && i < N0; i++) begin
            n_cmp++;
            if (q_addr[i] != i || q_w[i] != i + 1) begin
                n_err++; $display("FAIL full_write[%0d] got %0d/%0d exp %0d/%0d", i, q_addr[i], q_w[i], i, i + 1);
            end
        end
        n_cmp++;
        if (n_done != 1) begin n_err++; $display("FAIL full_done_count got %0d exp 1", n_done); end
`ifdef WLOAD_CHECKSUM_EN
        n_cmp++;
        if (o_checksum !== 13'sd325) begin n_err++; $display("FAIL full_checksum got %0d exp 325", o_checksum); end
`endif
    endtask

    task automatic test_stall();
        clear_sb();
        step(1, 0, 0, 0);
        step(0, 0, 1, -8'sd128);
        step(0, 0, 0, 8'sd55);
        step(0, 0, 0, 8'sd66);
        step(0, 0, 1, 8'sd127);
        step(0, 1, 0, 0);
        n_cmp++;
        if (q_addr.size() != 2) begin n_err++; $display("FAIL stall_count got %0d exp 2", q_addr.size()); end
        else begin
            n_cmp++;
            if (q_addr[0] != 0 || q_w[0] != -128 || q_addr[1] != 1 || q_w[1] != 127) begin
                n_err++; $display("FAIL stall_writes got %0d:%0d %0d:%0d exp 0:-128 1:127", q_addr[0], q_w[0], q_addr[1], q_w[1]);
            end
        end
    endtask

    task automatic test_abort();
        clear_sb();
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom));
        step(0, 1, 1, 8'sd77);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
        n_cmp++;
        if (q_addr.size() != 10 || n_done != 0) begin
            n_err++; $display("FAIL abort_writes got %0d done %0d exp 10 done 0", q_addr.size(), n_done);
        end
        clear_sb();
        step(1, 0, 0, 0);
        step(0, 0, 1, -8'sd7);
        n_cmp++;
        if (q_addr.size() != 1 || q_addr[0] != 0 || q_w[0] != -7) begin
            n_err++; $display("FAIL restart_write got n=%0d exp addr 0 w -7", q_addr.size());
        end
`ifdef WLOAD_CHECKSUM_EN
        n_cmp++;
        if (o_checksum !== -13'sd7) begin n_err++; $display("FAIL restart_checksum got %0d exp -7", o_checksum); end
`endif
        step(0, 1, 0, 0);
    endtask

    task automatic test_ignored_start();
        clear_sb();
        step(1, 0, 0, 0);
        for (int i = 0; i < N0; i++) step(i == 5, 0, 1, 8'($urandom));
        step(0, 0, 0, 0);
        n_cmp++;
        if (q_addr.size() != N0 || n_done != 1) begin
            n_err++; $display("FAIL ignored_start got %0d writes %0d done exp %0d 1", q_addr.size(), n_done, N0);
        end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_cmp++;
            if (q_addr[i] != i) begin n_err++; $display("FAIL ignored_start_addr[%0d] got %0d exp %0d", i, q_addr[i], i); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        clear_sb();
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 8'($urandom));
        s_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, o_w_en, o_addr, o_w, o_busy, o_done} !== '0) begin
            n_err++; $display("FAIL async_reset got %h exp 0", {s_ready, o_w_en, o_addr, o_w, o_busy, o_done});
        end
`ifdef WLOAD_CHECKSUM_EN
        n_cmp++;
        if (o_checksum !== '0) begin n_err++; $display("FAIL async_reset_checksum got %0d exp 0", o_checksum); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_sb();
        step(0, 0, 1, 8'sd3);
        step(1, 0, 0, 0);
        for (int i = 0; i < N0; i++) step(0, 0, 1, 8'($urandom));
        step(0, 0, 0, 0);
        n_cmp++;
        if (q_addr.size() != N0 || n_done != 1) begin
            n_err++; $display("FAIL post_reset_load got %0d writes %0d done exp %0d 1", q_addr.size(), n_done, N0);
        end
    endtask

    task automatic test_small();
        logic signed [7:0] tw[9];
        int sum;
        @(negedge clk);
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0; v1 = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready1, wen1, addr1, ow1, busy1, done1} !== '0) begin
            n_err++; $display("FAIL small_async_reset got %h exp 0", {ready1, wen1, addr1, ow1, busy1, done1});
        end
        @(negedge clk);
        rst_n = 1'b1; v1 = 1'b0;
        model_reset();
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0; v1 = 1'b1; sum = 0;
        for (int i = 0; i < 9; i++) begin
            w1 = 8'($urandom); tw[i] = w1; sum += int'(w1);
            #1;
            n_cmp++;
            if (ready1 !== 1'b1) begin n_err++; $display("FAIL small_ready[%0d] got %b exp 1", i, ready1); end
            @(negedge clk);
            n_cmp++;
            if (wen1 !== 1'b1 || addr1 !== 5'(4 + i) || ow1 !== tw[i] || done1 !== (i == 8)) begin
                n_err++; $display("FAIL small_write[%0d] got en %b addr %0d w %0d done %b exp 1 %0d %0d %b",
                                  i, wen1, addr1, ow1, done1, 4 + i, tw[i], i == 8);
            end
        end
`ifdef WLOAD_CHECKSUM_EN
        n_cmp++;
        if (cs1 !== 13'(sum)) begin n_err++; $display("FAIL small_checksum got %0d exp %0d", cs1, sum); end
`endif
        v1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wen1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || addr1 !== 5'd12) begin
            n_err++; $display("FAIL small_after got en %b busy %b done %b addr %0d exp 0 0 0 12", wen1, busy1, done1, addr1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_load();
        test_stall();
        test_abort();
        test_ignored_start();
        test_random();
        test_async_reset();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
